// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use hazard compare between EX load and ID sources
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  mem_read_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  hit_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hit_o = mem_read_i && (rd_addr_i != REG_X0) &&
                 ((rd_addr_i == rs1_addr_i) || (rd_addr_i == rs2_addr_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller with data-memory wait FSM and timeout
// Optional stall-cycle counter port stall_cnt_o enabled by PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS2addr_i,
  input  logic                  Branch_taken_i,
  input  logic                  EXMEM_MemRead_i,
  input  logic                  EXMEM_MemWrite_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_ack_i,
  output logic                  PCWrite_o,
  output logic                  IFID_Write_o,
  output logic                  IFID_Flush_o,
  output logic                  IDEX_Write_o,
  output logic                  IDEX_Flush_o,
  output logic                  EXMEM_Write_o,
  output logic                  MEMWB_Bubble_o,
  output logic                  timeout_o
`ifdef PIPE_STALL_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use_hit;

  pipe_hazard_detect u_hazard (
    .mem_read_i (IDEX_MemRead_i),
    .rd_addr_i  (IDEX_RDaddr_i),
    .rs1_addr_i (IFID_RS1addr_i),
    .rs2_addr_i (IFID_RS2addr_i),
    .hit_o      (load_use_hit)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    dmem_req_o     = 1'b0;
    PCWrite_o      = 1'b0;
    IFID_Write_o   = 1'b0;
    IFID_Flush_o   = 1'b0;
    IDEX_Write_o   = 1'b0;
    IDEX_Flush_o   = 1'b0;
    EXMEM_Write_o  = 1'b0;
    MEMWB_Bubble_o = 1'b0;
    timeout_o      = 1'b0;
    // While in reset every output stays low so no access can be launched
    if (!rst_i) begin
      case (state_q)
        RUN: begin
          PCWrite_o     = 1'b1;
          IFID_Write_o  = 1'b1;
          IDEX_Write_o  = 1'b1;
          EXMEM_Write_o = 1'b1;
          dmem_req_o    = EXMEM_MemRead_i | EXMEM_MemWrite_i;
          if (load_use_hit) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            IDEX_Flush_o = 1'b1;
          end else if (Branch_taken_i) begin
            IFID_Flush_o = 1'b1;
          end
          if (dmem_req_o && !dmem_ack_i) begin
            state_d    = MEMWAIT;
            wait_cnt_d = 8'd1;
          end
        end
        MEMWAIT: begin
          dmem_req_o = 1'b1;
          if (dmem_ack_i) begin
            PCWrite_o     = 1'b1;
            IFID_Write_o  = 1'b1;
            IDEX_Write_o  = 1'b1;
            EXMEM_Write_o = 1'b1;
            state_d       = RUN;
            wait_cnt_d    = 8'd0;
          end else begin
            MEMWB_Bubble_o = 1'b1;
            if (wait_cnt_q == WAIT_MAX_C) begin
              state_d = ERR;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        ERR: begin
          MEMWB_Bubble_o = 1'b1;
          timeout_o      = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = rst_i ? 32'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench: directed vector table, random vs reference model
// Covers the optional stall counter when PIPE_STALL_CTRL_PERF_EN is defined.
module tb_pipe_stall_ctrl;

  localparam int WMAX = 4;

  // Expected output word: {req, pcw, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, timeout}
  localparam logic [8:0] ZERO     = 9'b000000000;
  localparam logic [8:0] RUN_DEF  = 9'b011010100;
  localparam logic [8:0] RUN_REQ  = 9'b111010100;
  localparam logic [8:0] LOADUSE  = 9'b000011100;
  localparam logic [8:0] BRANCH   = 9'b011110100;
  localparam logic [8:0] FREEZE   = 9'b100000010;
  localparam logic [8:0] ERRST    = 9'b000000011;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [4:0] rd, rs1, rs2;
  logic       br, exmr, exmw, ack;
  logic       req, pcw, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, tmo;
  logic [8:0] obs;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .IDEX_MemRead_i   (mr),
    .IDEX_RDaddr_i    (rd),
    .IFID_RS1addr_i   (rs1),
    .IFID_RS2addr_i   (rs2),
    .Branch_taken_i   (br),
    .EXMEM_MemRead_i  (exmr),
    .EXMEM_MemWrite_i (exmw),
    .dmem_req_o       (req),
    .dmem_ack_i       (ack),
    .PCWrite_o        (pcw),
    .IFID_Write_o     (ifid_w),
    .IFID_Flush_o     (ifid_f),
    .IDEX_Write_o     (idex_w),
    .IDEX_Flush_o     (idex_f),
    .EXMEM_Write_o    (exmem_w),
    .MEMWB_Bubble_o   (bubble),
    .timeout_o        (tmo)
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt)
`endif
  );

  assign obs = {req, pcw, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, tmo};

  typedef struct {
    logic       rst, mr;
    logic [4:0] rd, rs1, rs2;
    logic       br, exmr, exmw, ack;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic m, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                              logic b, logic emr, logic emw, logic a, logic [8:0] e);
    vec_t v;
    v.rst = r; v.mr = m; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.br = b; v.exmr = emr; v.exmw = emw; v.ack = a; v.exp = e;
    return v;
  endfunction

  task automatic drive(vec_t v);
    rst = v.rst; mr = v.mr; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    br = v.br; exmr = v.exmr; exmw = v.exmw; ack = v.ack;
  endtask

  task automatic check9(string name, logic [8:0] got, logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: m_waited counts cycles spent waiting on memory (0 = not waiting)
  bit m_dead;
  int m_waited;

  function automatic logic [8:0] model_step(vec_t v);
    logic [8:0] e;
    logic hit, want;
    e = ZERO;
    if (v.rst) begin
      m_dead = 0;
      m_waited = 0;
    end else if (m_dead) begin
      e = ERRST;
    end else if (m_waited > 0) begin
      if (v.ack) begin
        e = RUN_REQ;
        m_waited = 0;
      end else begin
        e = FREEZE;
        if (m_waited == WMAX) m_dead = 1;
        else m_waited++;
      end
    end else begin
      hit  = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
      want = v.exmr || v.exmw;
      e = hit ? LOADUSE : (v.br ? BRANCH : RUN_DEF);
      e[8] = want;
      if (want && !v.ack) m_waited = 1;
    end
    return e;
  endfunction

  initial begin
    vec_t v;
    rst = 1; mr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; exmr = 0; exmw = 0; ack = 0;

    //          rst mr  rd   rs1  rs2  br exmr exmw ack  expected
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ZERO));
    tbl.push_back(mk(1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1, 1, ZERO));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, LOADUSE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 1, 5'd5, 5'd2, 5'd5, 1, 0, 0, 0, LOADUSE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd2, 5'd5, 1, 0, 0, 0, BRANCH));
    tbl.push_back(mk(0, 1, 5'd7, 5'd5, 5'd6, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, RUN_REQ));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, RUN_REQ));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, 0, FREEZE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, RUN_REQ));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, RUN_REQ));
    for (int i = 0; i < WMAX; i++) tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, FREEZE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, ERRST));
    tbl.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0, ERRST));
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, ZERO));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, RUN_REQ));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FREEZE));
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, ZERO));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, RUN_DEF));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check9($sformatf("tbl[%0d]", i), obs, tbl[i].exp);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model, starting from a reset
    v = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ZERO);
    for (int i = 0; i < 600; i++) begin
      logic [8:0] e;
      if (i > 0) begin
        v.rst  = ($urandom_range(0, 39) == 0);
        v.mr   = $urandom_range(0, 1);
        v.rd   = 5'($urandom_range(0, 3));
        v.rs1  = 5'($urandom_range(0, 3));
        v.rs2  = 5'($urandom_range(0, 3));
        v.br   = ($urandom_range(0, 3) == 0);
        v.exmr = ($urandom_range(0, 3) == 0);
        v.exmw = ($urandom_range(0, 5) == 0);
        v.ack  = ($urandom_range(0, 3) == 0);
      end
      drive(v);
      e = model_step(v);
      @(negedge clk);
      check9($sformatf("rand[%0d]", i), obs, e);
      @(posedge clk); #1;
    end

`ifdef PIPE_STALL_CTRL_PERF_EN
    begin
      vec_t seq[$];
      seq.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ZERO));
      seq.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
      seq.push_back(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, LOADUSE));
      seq.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, RUN_REQ));
      seq.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FREEZE));
      seq.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, FREEZE));
      seq.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, RUN_REQ));
      foreach (seq[i]) begin
        drive(seq[i]);
        @(negedge clk);
        check9($sformatf("perf_seq[%0d]", i), obs, seq[i].exp);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check32("stall_cnt_count", stall_cnt, 32'd3);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      drive(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, LOADUSE));
      @(posedge clk); #1;
      @(negedge clk);
      check32("stall_cnt_top", stall_cnt, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      @(negedge clk);
      check32("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
      drive(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ZERO));
      @(posedge clk); #1;
      drive(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, RUN_DEF));
      @(negedge clk);
      check32("stall_cnt_clr", stall_cnt, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
